// File: rtl/des_stream_pkg.sv
// Shared widths, FIFO entry layout and counter sizing for the DES stream front end.
package des_stream_pkg;

  localparam int DES_BLK_W = 64;
  localparam int DES_KEY_W = 64;
  localparam int DES_TAG_W = 8;

  typedef struct packed {
    logic [DES_BLK_W-1:0] data;
    logic [DES_TAG_W-1:0] tag;
  } des_stream_entry_t;

  // The credit counter must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/des_stream_fifo.sv
// Single-clock result FIFO with a registered head stage; writes reach the head one cycle later.
module des_stream_fifo
  import des_stream_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = des_stream_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_en,
  input  entry_t wr_entry,
  output logic   rd_valid,
  input  logic   rd_ready,
  output entry_t rd_entry
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          st_empty;
  logic          head_load;
  logic          st_write;

  // The extra pointer MSB separates full from empty when the index bits match.
  assign st_empty  = (wr_ptr == rd_ptr);
  assign head_load = !rd_valid || rd_ready;
  assign st_write  = wr_en && !(head_load && st_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_entry <= '0;
    end else begin
      if (head_load) begin
        if (!st_empty) begin
          rd_entry <= mem[rd_ptr[AW-1:0]];
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + PTR_ONE;
        end else if (wr_en) begin
          rd_entry <= wr_entry;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
      if (st_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
    end
  end

  // NOTE: storage is deliberately left unreset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (st_write) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

endmodule

// File: rtl/des_stream_ctrl.sv
// Valid/ready wrapper for a non-stallable pipelined DES core: slot tracking, credits, result FIFO.
module des_stream_ctrl
  import des_stream_pkg::*;
#(
  parameter int LATENCY    = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_W      = DES_TAG_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DES_BLK_W-1:0]               in_data,
  input  logic [DES_KEY_W-1:0]               in_key,
  input  logic [TAG_W-1:0]                   in_tag,
  output logic [DES_BLK_W-1:0]               core_in,
  output logic [DES_KEY_W-1:0]               core_key,
  input  logic [DES_BLK_W-1:0]               core_out,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DES_BLK_W-1:0]               out_data,
  output logic [TAG_W-1:0]                   out_tag,
  output logic [cnt_width(FIFO_DEPTH)-1:0]   inflight,
  output logic                               idle
);

  localparam int CW = cnt_width(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef struct packed {
    logic [DES_BLK_W-1:0] data;
    logic [TAG_W-1:0]     tag;
  } entry_t;

  logic               accept;
  logic               pop;
  logic [LATENCY-1:0] trk_valid;
  logic [TAG_W-1:0]   trk_tag [LATENCY];
  entry_t             wr_entry;
  entry_t             rd_entry;

  // Credits cover core slots plus FIFO entries, so a capture always finds room.
  assign in_ready = (inflight < FULL_CNT);
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign idle     = (inflight == '0);

  assign core_in  = accept ? in_data : '0;
  assign core_key = accept ? in_key  : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_valid <= '0;
    end else begin
      trk_valid <= {trk_valid[LATENCY-2:0], accept};
    end
  end

  // Tags ride alongside the valid bits and are only ever qualified by them.
  always_ff @(posedge clk) begin
    trk_tag[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) begin
      trk_tag[i] <= trk_tag[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase
    end
  end

  assign wr_entry = '{data: core_out, tag: trk_tag[LATENCY-1]};

  des_stream_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (trk_valid[LATENCY-1]),
    .wr_entry (wr_entry),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_entry (rd_entry)
  );

  assign out_data = rd_entry.data;
  assign out_tag  = rd_entry.tag;

endmodule

// File: tb/tb_des_stream_ctrl.sv
// Scoreboard bench: dut_a (depth 16) for KAT/backpressure/reset/bubbles, dut_b (depth 32) for streaming.
module tb_des_stream_ctrl;

  localparam int LAT = 16;
  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in for the des core: the known-answer pair from a table, otherwise a cheap mix.
  function automatic logic [63:0] core_fn(input logic [63:0] d, input logic [63:0] k);
    if (d == KAT_PT && k == KAT_KEY) return KAT_CT;
    return d ^ {k[31:0], k[63:32]} ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  // ---------------- DUT A ----------------
  logic        rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, idle_a;
  logic [63:0] in_data_a, in_key_a, core_in_a, core_key_a, core_out_a, out_data_a;
  logic [7:0]  in_tag_a, out_tag_a;
  logic [4:0]  inflight_a;
  logic [63:0] pipe_a [LAT];

  des_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(16), .TAG_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .in_key(in_key_a), .in_tag(in_tag_a),
    .core_in(core_in_a), .core_key(core_key_a), .core_out(core_out_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_tag(out_tag_a), .inflight(inflight_a), .idle(idle_a)
  );

  always @(posedge clk) begin
    pipe_a[0] <= core_fn(core_in_a, core_key_a);
    for (int i = 1; i < LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign core_out_a = pipe_a[LAT-1];

  // ---------------- DUT B ----------------
  logic        rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, idle_b;
  logic [63:0] in_data_b, in_key_b, core_in_b, core_key_b, core_out_b, out_data_b;
  logic [7:0]  in_tag_b, out_tag_b;
  logic [5:0]  inflight_b;
  logic [63:0] pipe_b [LAT];

  des_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(32), .TAG_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .in_key(in_key_b), .in_tag(in_tag_b),
    .core_in(core_in_b), .core_key(core_key_b), .core_out(core_out_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_tag(out_tag_b), .inflight(inflight_b), .idle(idle_b)
  );

  always @(posedge clk) begin
    pipe_b[0] <= core_fn(core_in_b, core_key_b);
    for (int i = 1; i < LAT; i++) pipe_b[i] <= pipe_b[i-1];
  end
  assign core_out_b = pipe_b[LAT-1];

  // ---------------- scoreboards ----------------
  exp_t qa[$];
  exp_t qb[$];
  bit   bubble_mode = 1'b0;
  int   bubble_pops = 0;
  int   a_last_pop  = -1;
  bit   b_stream    = 1'b0;
  int   b_pops      = 0;
  int   b_stalls    = 0;
  int   b_last_pop  = -1;

  // Input side: expected results are pushed at the moment a block is issued.
  always @(negedge clk) begin
    if (!rst_a) begin
      if (in_valid_a && in_ready_a) begin
        qa.push_back('{core_fn(in_data_a, in_key_a), in_tag_a});
      end else if (in_valid_a) begin
        check("a_core_in_gated", core_in_a | core_key_a, 64'd0);
      end
    end
    if (!rst_b) begin
      if (in_valid_b && in_ready_b) qb.push_back('{core_fn(in_data_b, in_key_b), in_tag_b});
      if (b_stream && in_valid_b && !in_ready_b) b_stalls++;
    end
  end

  // Output side: pop and compare whenever the DUT hands over a result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a && out_valid_a && out_ready_a) begin
      if (qa.size() == 0) begin
        check("a_unexpected_output_tag", {56'd0, out_tag_a}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = qa.pop_front();
        check("a_data", out_data_a, e.data);
        check("a_tag", {56'd0, out_tag_a}, {56'd0, e.tag});
      end
      if (bubble_mode) begin
        if (a_last_pop >= 0) check("a_bubble_spacing", 64'(cyc - a_last_pop), 64'd2);
        bubble_pops++;
      end
      a_last_pop = cyc;
    end
    if (!rst_b && out_valid_b && out_ready_b) begin
      if (qb.size() == 0) begin
        check("b_unexpected_output_tag", {56'd0, out_tag_b}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = qb.pop_front();
        check("b_data", out_data_b, e.data);
        check("b_tag", {56'd0, out_tag_b}, {56'd0, e.tag});
      end
      if (b_stream) begin
        if (b_last_pop >= 0) check("b_stream_spacing", 64'(cyc - b_last_pop), 64'd1);
        b_pops++;
      end
      b_last_pop = cyc;
    end
  end

  // ---------------- helpers ----------------
  task automatic drain_a(input string nm);
    int n = 0;
    while ((qa.size() != 0 || out_valid_a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drained"}, 64'(qa.size()), 64'd0);
  endtask

  task automatic kat_a(input string nm);
    int acc_cyc;
    int n;
    @(posedge clk); #1;
    in_valid_a = 1'b1; in_data_a = KAT_PT; in_key_a = KAT_KEY; in_tag_a = 8'h5A;
    out_ready_a = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_a && n < 40);
    check({nm, "_latency"}, 64'(cyc - acc_cyc), 64'd17);
    check({nm, "_data"}, out_data_a, KAT_CT);
    check({nm, "_tag"}, {56'd0, out_tag_a}, 64'h5A);
    drain_a(nm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int over;
    rst_a = 1'b1; rst_b = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0; in_key_a = '0; in_tag_a = '0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_data_b = '0; in_key_b = '0; in_tag_b = '0; out_ready_b = 1'b0;
    #12;
    check("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    check("rst_idle", {63'd0, idle_a}, 64'd1);
    check("rst_inflight", {59'd0, inflight_a}, 64'd0);
    check("rst_out_data", out_data_a, 64'd0);
    check("rst_out_tag", {56'd0, out_tag_a}, 64'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    kat_a("kat_cold");

    // Streaming on the deep instance: 100 back-to-back blocks.
    out_ready_b = 1'b1;
    b_stream = 1'b1;
    b_last_pop = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      in_valid_b = 1'b1; in_data_b = 64'(i); in_key_b = 64'h0F1E_2D3C_4B5A_6978; in_tag_b = 8'(i);
    end
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    for (int n = 0; n < 400 && (qb.size() != 0 || out_valid_b); n++) @(negedge clk);
    check("stream_drained", 64'(qb.size()), 64'd0);
    check("stream_pops", 64'(b_pops), 64'd100);
    check("stream_no_stall", 64'(b_stalls), 64'd0);
    b_stream = 1'b0;

    // Backpressure: sink stalled, source continuous.
    out_ready_a = 1'b0;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      in_valid_a = 1'b1; in_data_a = 64'h1000 + 64'(k); in_key_a = 64'hDEAD_BEEF_0000_0000 | 64'(k);
      in_tag_a = 8'h80 + 8'(k);
      @(negedge clk);
      if (in_valid_a && in_ready_a) acc++;
    end
    check("bp_accepts", 64'(acc), 64'd16);
    check("bp_in_ready_low", {63'd0, in_ready_a}, 64'd0);
    check("bp_inflight_full", {59'd0, inflight_a}, 64'd16);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    @(negedge clk);
    check("bp_first_pop_valid", {63'd0, out_valid_a}, 64'd1);
    check("bp_ready_at_first_pop", {63'd0, in_ready_a}, 64'd0);
    @(negedge clk);
    check("bp_ready_after_pop", {63'd0, in_ready_a}, 64'd1);
    drain_a("bp");

    // Simultaneous accept and pop around the credit limit.
    over = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      in_valid_a = 1'b1; in_data_a = {$urandom, $urandom}; in_key_a = {$urandom, $urandom};
      in_tag_a = 8'(k);
      out_ready_a = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (inflight_a > 5'd16) over++;
    end
    check("rand_inflight_bound", 64'(over), 64'd0);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    drain_a("rand");

    // Reset with 10 blocks inside the core.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid_a = 1'b1; in_data_a = 64'h5000 + 64'(k); in_key_a = 64'h7777; in_tag_a = 8'h40 + 8'(k);
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    rst_a = 1'b1;
    qa.delete();
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid_a}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready_a}, 64'd1);
    check("mid_rst_inflight", {59'd0, inflight_a}, 64'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    for (int n = 0; n < 30; n++) @(negedge clk);
    check("post_rst_inflight", {59'd0, inflight_a}, 64'd0);
    kat_a("kat_after_rst");

    // Idle bubbles: alternating source, sink always ready.
    bubble_mode = 1'b1;
    bubble_pops = 0;
    a_last_pop  = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      in_valid_a = (k % 2 == 0); in_data_a = 64'hB000 + 64'(k); in_key_a = 64'h1234; in_tag_a = 8'(k);
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    drain_a("bubble");
    check("bubble_pops", 64'(bubble_pops), 64'd20);
    @(negedge clk);
    check("bubble_idle", {63'd0, idle_a}, 64'd1);
    bubble_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
